drbg_pad_buffer: RTL and testbench

DRBG_PAD_BUFFER -- requirements
Module: drbg_pad_buffer

---
 rtl/drbg_pkg.sv | 6 +
 rtl/drbg_pad_buffer.sv | 90 +++++++++
 tb/tb_drbg_pad_buffer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/drbg_pkg.sv
// drbg_pkg: shared widths and block type for the DRBG pad path.
package drbg_pkg;
   localparam int AES_BLOCK_LENGTH = 128;
   localparam int PAD_WORD_WIDTH   = 64;
   typedef logic [AES_BLOCK_LENGTH-1:0] pad_block_t;
endpackage

// File: rtl/drbg_pad_buffer.sv
// drbg_pad_buffer: FIFO of DRBG blocks served to the consumer as 64-bit words, lo half first.
// Defining DRBG_PAD_ZEROIZE_EN scrubs popped entries and clears storage on flush and reset.
module drbg_pad_buffer
   import drbg_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        blk_valid_i,
   input  logic [AES_BLOCK_LENGTH-1:0] blk_i,
   input  logic                        flush_i,
   output logic [PAD_WORD_WIDTH-1:0]   word_o,
   output logic                        word_valid_o,
   input  logic                        word_ready_i,
   output logic [$clog2(DEPTH):0]      level_o,
   output logic                        overflow_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   pad_block_t     mem_q [DEPTH];
   pad_block_t     mem_d [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;
   logic           half_q, half_d, overflow_q, overflow_d;
   logic           xfer, pop, wr_ok;
   pad_block_t     head;

   assign head         = mem_q[rd_ptr_q];
   assign word_valid_o = reset_n && (count_q != '0);
   assign word_o       = word_valid_o ? (half_q ? head[127:64] : head[63:0]) : '0;
   assign level_o      = reset_n ? count_q : '0;
   assign overflow_o   = overflow_q;
   assign xfer         = word_valid_o && word_ready_i;
   assign pop          = xfer && half_q;
   // a full FIFO still takes the block when the head leaves in the same cycle
   assign wr_ok        = blk_valid_i && ((count_q != FULL) || pop);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      half_d     = half_q;
      overflow_d = overflow_q;
      if (flush_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         half_d     = 1'b0;
         overflow_d = 1'b0;
      end else begin
         half_d     = xfer ? ~half_q : half_q;
         rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
         wr_ptr_d   = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
         overflow_d = overflow_q || (blk_valid_i && !wr_ok);
         count_d    = (wr_ok && !pop) ? count_q + 1'b1 : (pop && !wr_ok) ? count_q - 1'b1 : count_q;
      end
   end

   always_comb begin
      mem_d = mem_q;
`ifdef DRBG_PAD_ZEROIZE_EN
      if (!reset_n || flush_i) begin
         for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      end else if (pop) begin
         mem_d[rd_ptr_q] = '0;
      end
`endif
      // write after the scrub so a full-plus-pop write into the head slot survives
      if (reset_n && !flush_i && wr_ok) mem_d[wr_ptr_q] = blk_i;
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         half_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         half_q     <= half_d;
         overflow_q <= overflow_d;
      end
   end
endmodule

// File: tb/tb_drbg_pad_buffer.sv
// tb_drbg_pad_buffer: directed and random stimulus checked every cycle against a block-queue model.
module tb_drbg_pad_buffer;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic           clk = 1'b0;
   logic           reset_n, blk_valid_i, flush_i, word_ready_i;
   logic [127:0]   blk_i;
   logic [63:0]    word_o;
   logic           word_valid_o, overflow_o;
   logic [LW-1:0]  level_o;

   int             n_chk = 0, n_fail = 0;
   logic [127:0]   mq[$];
   bit             mh = 1'b0, mo = 1'b0;

   drbg_pad_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .blk_valid_i(blk_valid_i), .blk_i(blk_i),
      .flush_i(flush_i), .word_o(word_o), .word_valid_o(word_valid_o),
      .word_ready_i(word_ready_i), .level_o(level_o), .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rnd_blk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic step(input bit rn, input bit v, input logic [127:0] b, input bit fl, input bit rdy);
      bit xfer, pop, ok;
      logic [63:0] ew;
      reset_n = rn; blk_valid_i = v; blk_i = b; flush_i = fl; word_ready_i = rdy;
      xfer = rn && mq.size() != 0 && rdy;
      pop  = xfer && mh;
      ok   = v && (mq.size() < DEPTH || pop);
      @(posedge clk);
      if (!rn || fl) begin
         mq.delete(); mh = 1'b0; mo = 1'b0;
      end else begin
         if (xfer) begin
            if (mh) void'(mq.pop_front());
            mh = !mh;
         end
         if (ok) mq.push_back(b);
         else if (v) mo = 1'b1;
      end
      @(negedge clk);
      ew = 64'h0;
      if (rn && mq.size() != 0) ew = mh ? mq[0][127:64] : mq[0][63:0];
      check("valid", word_valid_o, rn && mq.size() != 0);
      check("level", level_o, rn ? mq.size() : 0);
      check("word", word_o, ew);
      check("overflow", overflow_o, mo);
   endtask

   task automatic idle(input bit rdy);
      step(1'b1, 1'b0, 128'h0, 1'b0, rdy);
   endtask

   initial begin
      logic [127:0] b1, b2;
      reset_n = 1'b0; blk_valid_i = 1'b0; blk_i = '0; flush_i = 1'b0; word_ready_i = 1'b0;
      @(negedge clk);
      step(1'b0, 1'b0, 128'h0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 128'h55, 1'b0, 1'b1);
      check("rst_level", level_o, 0);
      // fill and drain three blocks
      for (int k = 1; k <= 3; k++) step(1'b1, 1'b1, 128'(k), 1'b0, 1'b1);
      for (int k = 0; k < 8; k++) idle(1'b1);
      check("drain_level", level_o, 0);
      check("drain_valid", word_valid_o, 0);
      // overflow with a stalled consumer
      step(1'b0, 1'b0, 128'h0, 1'b0, 1'b0);
      b1 = rnd_blk();
      step(1'b1, 1'b1, b1, 1'b0, 1'b0);
      for (int k = 1; k <= DEPTH; k++) step(1'b1, 1'b1, rnd_blk(), 1'b0, 1'b0);
      check("ovf_flag", overflow_o, 1);
      check("ovf_level", level_o, DEPTH);
      check("ovf_head", word_o, b1[63:0]);
      // full-plus-pop write
      step(1'b1, 1'b0, 128'h0, 1'b1, 1'b0);
      for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b1, rnd_blk(), 1'b0, 1'b0);
      idle(1'b1);
      step(1'b1, 1'b1, rnd_blk(), 1'b0, 1'b1);
      check("fpp_level", level_o, DEPTH);
      check("fpp_ovf", overflow_o, 0);
      // flush collision
      step(1'b1, 1'b1, rnd_blk(), 1'b0, 1'b0);
      step(1'b1, 1'b1, rnd_blk(), 1'b1, 1'b1);
      check("flush_level", level_o, 0);
      check("flush_ovf", overflow_o, 0);
      check("flush_valid", word_valid_o, 0);
      // reset in the middle of a block
      b1 = rnd_blk(); b2 = rnd_blk();
      step(1'b1, 1'b1, b1, 1'b0, 1'b0);
      idle(1'b1);
      step(1'b0, 1'b0, 128'h0, 1'b0, 1'b0);
      step(1'b1, 1'b1, b2, 1'b0, 1'b0);
      check("midrst_word", word_o, b2[63:0]);
      // pointer wrap at a sustainable rate
      for (int c = 0; c < 12 * DEPTH + 8; c++)
         step(1'b1, (c % 4 == 0) && (c < 12 * DEPTH), rnd_blk(), 1'b0, c % 2 == 1);
      check("wrap_ovf", overflow_o, 0);
      check("wrap_level", level_o, 0);
      // random traffic
      for (int c = 0; c < 600; c++)
         step($urandom_range(0, 63) != 0, $urandom_range(0, 1) == 1, rnd_blk(),
              $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
